hwjsoc_cpu_oci_dtrace_packer: RTL and testbench

Parametrised data-trace packer for the CPU on-chip-instrumentation (OCI) block. It accepts fixed-width trace frames one per cycle and packs them LSB-first into a capture buffer. Each full (or, at test end, partial) buffer is queued into a small show-ahead FIFO for the trace sink. On test_ending it flushes and drains, then raises test_has_ended, giving the simulation/debug harness a clean end-of-trace indication.

---
 rtl/hwjsoc_oci_pkg.sv | 20 ++
 rtl/hwjsoc_oci_trace_fifo.sv | 49 ++++
 rtl/hwjsoc_cpu_oci_dtrace_packer.sv | 139 +++++++++++++
 tb/tb_hwjsoc_cpu_oci_dtrace_packer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwjsoc_oci_pkg.sv
// Shared definitions for the OCI data-trace packer: packer state encoding,
// default frame geometry and the frame-count width helper.
package hwjsoc_oci_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } oci_state_t;

  localparam int DEF_FRAME_W    = 2;
  localparam int DEF_NUM_FRAMES = 15;

  // Width needed to hold a frame count from 0 up to num_frames inclusive.
  function automatic int cnt_width(input int num_frames);
    return $clog2(num_frames + 1);
  endfunction

endpackage

// File: rtl/hwjsoc_oci_trace_fifo.sv
// Show-ahead FIFO for packed trace words. The pointers carry one extra wrap
// bit so that full and empty are told apart without a separate counter.
// The head is presented as zero while empty so a drained FIFO looks clean.
module hwjsoc_oci_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  // Advance the read and write pointers; full/empty come from the wrap bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/hwjsoc_cpu_oci_dtrace_packer.sv
// Data-trace packer: gathers fixed-width trace frames LSB-first into a word,
// queues full words (or the final partial word) into a show-ahead FIFO and,
// once asked to end, flushes, drains and raises a sticky end-of-trace flag.
module hwjsoc_cpu_oci_dtrace_packer
  import hwjsoc_oci_pkg::*;
#(
  parameter  int FRAME_W    = DEF_FRAME_W,
  parameter  int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter  int FIFO_DEPTH = 4,
  parameter  int DROP_W     = 16,
  localparam int CNT_W      = cnt_width(NUM_FRAMES),
  localparam int WORD_W     = FRAME_W * NUM_FRAMES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic              test_ending,
  output logic [WORD_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [CNT_W-1:0]  word_count,
  input  logic              word_ready,
  output logic              test_has_ended,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam int ENTRY_W = WORD_W + CNT_W;

  oci_state_t         state;
  oci_state_t         state_next;
  logic [WORD_W-1:0]  buf_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [WORD_W-1:0]  frame_ins;
  logic               last_slot;
  logic               drop;
  logic               fifo_push;
  logic [ENTRY_W-1:0] push_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head_entry;

  // Buffer bits above dct_count are always zero, so OR-ing in the shifted
  // frame places it without masking.
  assign frame_ins = dct_buffer | (WORD_W'(frame_data) << (FRAME_W * int'(dct_count)));
  assign last_slot = (dct_count == CNT_W'(NUM_FRAMES - 1));

  // Next-state and packing decisions; push eligibility uses start-of-cycle full.
  always_comb begin
    state_next = state;
    buf_next   = dct_buffer;
    cnt_next   = dct_count;
    fifo_push  = 1'b0;
    push_entry = '0;
    drop       = 1'b0;
    unique case (state)
      RUN: begin
        if (frame_valid) begin
          if (!last_slot) begin
            buf_next = frame_ins;
            cnt_next = dct_count + CNT_W'(1);
          end else if (!fifo_full) begin
            fifo_push  = 1'b1;
            push_entry = {CNT_W'(NUM_FRAMES), frame_ins};
            buf_next   = '0;
            cnt_next   = '0;
          end else begin
            drop = 1'b1;
          end
        end
        if (test_ending) state_next = FLUSH;
      end
      FLUSH: begin
        if (dct_count == '0) begin
          state_next = DRAIN;
        end else if (!fifo_full) begin
          fifo_push  = 1'b1;
          push_entry = {dct_count, dct_buffer};
          buf_next   = '0;
          cnt_next   = '0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_next = DONE;
      end
      DONE: begin
        state_next = DONE;
      end
      default: state_next = RUN;
    endcase
  end

  // State register and packing buffer; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else begin
      state      <= state_next;
      dct_buffer <= buf_next;
      dct_count  <= cnt_next;
    end
  end

  // Sticky overflow flag and saturating count of frames lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end

  hwjsoc_oci_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (word_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head_entry)
  );

  assign word_valid     = !fifo_empty;
  assign word_data      = head_entry[WORD_W-1:0];
  assign word_count     = head_entry[ENTRY_W-1:WORD_W];
  assign test_has_ended = (state == DONE);

endmodule

// File: tb/tb_hwjsoc_cpu_oci_dtrace_packer.sv
// Self-checking bench for the OCI data-trace packer: a directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// queue-based reference model.
module tb_hwjsoc_cpu_oci_dtrace_packer;

  localparam int FW    = 2;
  localparam int NF    = 15;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int CW    = 4;
  localparam int WW    = FW * NF;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic          test_ending;
  logic          word_ready;
  logic [WW-1:0] dct_buffer;
  logic [CW-1:0] dct_count;
  logic          word_valid;
  logic [WW-1:0] word_data;
  logic [CW-1:0] word_count;
  logic          test_has_ended;
  logic          overflow;
  logic [DW-1:0] drop_count;

  hwjsoc_cpu_oci_dtrace_packer #(
    .FRAME_W    (FW),
    .NUM_FRAMES (NF),
    .FIFO_DEPTH (DEPTH),
    .DROP_W     (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .word_count     (word_count),
    .word_ready     (word_ready),
    .test_has_ended (test_has_ended),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending frames, queued words and end-of-trace progress.
  typedef struct {
    logic [WW-1:0] data;
    int            cnt;
  } word_t;

  word_t         m_fifo[$];
  logic [FW-1:0] m_pend[$];
  int            m_drops;
  bit            m_ovf;
  bit            m_flushing;
  bit            m_draining;
  bit            m_ended;

  function automatic word_t make_word();
    word_t w;
    w.data = '0;
    for (int i = 0; i < m_pend.size(); i++) w.data[i*FW +: FW] = m_pend[i];
    w.cnt = m_pend.size();
    return w;
  endfunction

  function automatic void model_step(input bit rst, input bit fv, input logic [FW-1:0] fd,
                                     input bit te, input bit wr);
    bit full_now;
    bit empty_now;
    word_t w;
    if (rst) begin
      m_fifo.delete();
      m_pend.delete();
      m_drops    = 0;
      m_ovf      = 0;
      m_flushing = 0;
      m_draining = 0;
      m_ended    = 0;
      return;
    end
    full_now  = (m_fifo.size() == DEPTH);
    empty_now = (m_fifo.size() == 0);
    if (!empty_now && wr) void'(m_fifo.pop_front());
    if (m_ended) begin
    end else if (m_draining) begin
      if (empty_now) begin
        m_draining = 0;
        m_ended    = 1;
      end
    end else if (m_flushing) begin
      if (m_pend.size() == 0) begin
        m_flushing = 0;
        m_draining = 1;
      end else if (!full_now) begin
        w = make_word();
        m_fifo.push_back(w);
        m_pend.delete();
        m_flushing = 0;
        m_draining = 1;
      end
    end else begin
      if (fv) begin
        if (m_pend.size() < NF - 1) begin
          m_pend.push_back(fd);
        end else if (!full_now) begin
          m_pend.push_back(fd);
          w = make_word();
          m_fifo.push_back(w);
          m_pend.delete();
        end else begin
          m_ovf = 1;
          if (m_drops < (1 << DW) - 1) m_drops++;
        end
      end
      if (te) m_flushing = 1;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output();
    word_t w;
    w = make_word();
    check("dct_count", 64'(dct_count), 64'(m_pend.size()));
    check("dct_buffer", 64'(dct_buffer), 64'(w.data));
    check("word_valid", 64'(word_valid), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      check("word_data", 64'(word_data), 64'(m_fifo[0].data));
      check("word_count", 64'(word_count), 64'(m_fifo[0].cnt));
    end
    check("test_has_ended", 64'(test_has_ended), 64'(m_ended));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(reset, frame_valid, frame_data, test_ending, word_ready);
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input bit fv, input logic [FW-1:0] fd, input bit te);
    frame_valid = fv;
    frame_data  = fd;
    test_ending = te;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply_stimulus(0, '0, 0);
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    bit            fv;
    logic [FW-1:0] fd;
    bit            te;
    int            exp_cnt;
    logic [WW-1:0] exp_buf;
    bit            exp_wv;
    logic [WW-1:0] exp_wdata;
    int            exp_wcnt;
    bit            exp_end;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pops;
    int last_cnt;
    int zero_seen;

    reset       = 1'b1;
    word_ready  = 1'b1;
    apply_stimulus(0, '0, 0);

    // Reset state.
    do_reset();
    check("reset_dct_count", 64'(dct_count), 64'd0);
    check("reset_word_valid", 64'(word_valid), 64'd0);
    check("reset_word_data", 64'(word_data), 64'd0);
    check("reset_ended", 64'(test_has_ended), 64'd0);

    // Directed table: a 3-frame partial word flushed out, then DONE is held.
    vecs[0] = '{1'b1, 2'b11, 1'b0, 1, 30'h3,  1'b0, 30'h0,  0, 1'b0};
    vecs[1] = '{1'b1, 2'b10, 1'b0, 2, 30'hB,  1'b0, 30'h0,  0, 1'b0};
    vecs[2] = '{1'b1, 2'b01, 1'b0, 3, 30'h1B, 1'b0, 30'h0,  0, 1'b0};
    vecs[3] = '{1'b0, 2'b00, 1'b1, 3, 30'h1B, 1'b0, 30'h0,  0, 1'b0};
    vecs[4] = '{1'b1, 2'b11, 1'b0, 0, 30'h0,  1'b1, 30'h1B, 3, 1'b0};
    vecs[5] = '{1'b0, 2'b00, 1'b0, 0, 30'h0,  1'b0, 30'h0,  0, 1'b0};
    vecs[6] = '{1'b0, 2'b00, 1'b0, 0, 30'h0,  1'b0, 30'h0,  0, 1'b1};
    vecs[7] = '{1'b1, 2'b01, 1'b1, 0, 30'h0,  1'b0, 30'h0,  0, 1'b1};
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].fv, vecs[i].fd, vecs[i].te);
      step();
      check("vec_dct_count", 64'(dct_count), 64'(vecs[i].exp_cnt));
      check("vec_dct_buffer", 64'(dct_buffer), 64'(vecs[i].exp_buf));
      check("vec_word_valid", 64'(word_valid), 64'(vecs[i].exp_wv));
      if (vecs[i].exp_wv) begin
        check("vec_word_data", 64'(word_data), 64'(vecs[i].exp_wdata));
        check("vec_word_count", 64'(word_count), 64'(vecs[i].exp_wcnt));
      end
      check("vec_ended", 64'(test_has_ended), 64'(vecs[i].exp_end));
    end

    // Fifteen frames of 01 form one full word.
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < NF; i++) begin
      apply_stimulus(1, 2'b01, 0);
      step();
    end
    check("full_word_valid", 64'(word_valid), 64'd1);
    check("full_word_data", 64'(word_data), 64'h15555555);
    check("full_word_count", 64'(word_count), 64'd15);
    check("full_dct_count", 64'(dct_count), 64'd0);
    check("full_overflow", 64'(overflow), 64'd0);

    // Seven frames of 11 then a test_ending pulse: partial word of 7.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1, 2'b11, 0);
      step();
    end
    apply_stimulus(0, '0, 1);
    step();
    apply_stimulus(0, '0, 0);
    step();
    check("partial_word_valid", 64'(word_valid), 64'd1);
    check("partial_word_data", 64'(word_data), 64'h3FFF);
    check("partial_word_count", 64'(word_count), 64'd7);
    for (int i = 0; i < 10 && !test_has_ended; i++) step();
    check("partial_ended", 64'(test_has_ended), 64'd1);

    // Stalled sink: 89 frames fill four words, hold 14 and drop 15.
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 89; i++) begin
      apply_stimulus(1, FW'($urandom), 0);
      step();
    end
    check("stall_drop_count", 64'(drop_count), 64'd15);
    check("stall_overflow", 64'(overflow), 64'd1);
    check("stall_dct_count", 64'(dct_count), 64'd14);
    word_ready = 1'b1;
    apply_stimulus(0, '0, 1);
    pops = 0;
    last_cnt = -1;
    for (int i = 0; i < 40 && !test_has_ended; i++) begin
      if (word_valid && word_ready) begin
        pops++;
        last_cnt = int'(word_count);
      end
      step();
      apply_stimulus(0, '0, 0);
    end
    check("stall_pops", 64'(pops), 64'd5);
    check("stall_last_count", 64'(last_cnt), 64'd14);
    check("stall_ended", 64'(test_has_ended), 64'd1);

    // test_ending together with the 15th frame: one full word, no empty word.
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < NF - 1; i++) begin
      apply_stimulus(1, 2'b10, 0);
      step();
    end
    apply_stimulus(1, 2'b10, 1);
    step();
    check("edge_word_count", 64'(word_count), 64'd15);
    check("edge_dct_count", 64'(dct_count), 64'd0);
    apply_stimulus(0, '0, 0);
    pops = 0;
    zero_seen = 0;
    for (int i = 0; i < 10 && !test_has_ended; i++) begin
      if (word_valid && word_ready) begin
        pops++;
        if (word_count == '0) zero_seen++;
      end
      step();
    end
    check("edge_pops", 64'(pops), 64'd1);
    check("edge_zero_words", 64'(zero_seen), 64'd0);
    check("edge_ended", 64'(test_has_ended), 64'd1);

    // Minimum latency from test_ending to test_has_ended, then held.
    do_reset();
    apply_stimulus(0, '0, 1);
    step();
    check("lat_n", 64'(test_has_ended), 64'd0);
    apply_stimulus(0, '0, 0);
    step();
    check("lat_n1", 64'(test_has_ended), 64'd0);
    step();
    check("lat_n2", 64'(test_has_ended), 64'd1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 2'b11, 1);
      step();
    end
    check("lat_hold", 64'(test_has_ended), 64'd1);
    check("lat_hold_count", 64'(dct_count), 64'd0);

    // Reset while stuck in FLUSH with a full FIFO and a stalled sink.
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 63; i++) begin
      apply_stimulus(1, FW'($urandom), 0);
      step();
    end
    apply_stimulus(0, '0, 1);
    step();
    apply_stimulus(0, '0, 0);
    for (int i = 0; i < 3; i++) step();
    check("flush_stuck_ended", 64'(test_has_ended), 64'd0);
    check("flush_stuck_count", 64'(dct_count), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_word_valid", 64'(word_valid), 64'd0);
    check("abort_dct_count", 64'(dct_count), 64'd0);
    check("abort_dct_buffer", 64'(dct_buffer), 64'd0);
    check("abort_word_data", 64'(word_data), 64'd0);
    check("abort_ended", 64'(test_has_ended), 64'd0);
    word_ready = 1'b1;
    for (int i = 0; i < NF; i++) begin
      apply_stimulus(1, 2'b01, 0);
      step();
    end
    check("abort_new_word", 64'(word_data), 64'h15555555);
    check("abort_new_count", 64'(word_count), 64'd15);

    // Randomized traffic with varying sink stall rates.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        word_ready = (seg < 3) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        apply_stimulus($urandom_range(0, 3) != 0, FW'($urandom), $urandom_range(0, 149) == 0);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
